pass_engine: RTL and testbench

Pass engine for the on-chip training loop. It answers the training controller's pass-level commands (f0/f1 forward, backward) by stepping the datapath through samples or weights, accumulating forward-pass loss, and returning the completion handshakes `f_end`/`b_end` and the converged flag `zero_end_check`. It also honours the controller's clear strobes for loss, final loss and the weight-update count.

---
 rtl/pass_engine.sv | 150 +++++++++++++++
 tb/tb_pass_engine.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pass_engine.sv
// Pass engine: steps the datapath through forward (loss-accumulating) and
// backward (weight-update) passes on command from the training controller.
module pass_engine #(
  parameter int IDX_W     = 3,
  parameter int FWD_STEPS = 8,
  parameter int BWD_STEPS = 4,
  parameter int LOSS_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              f0_pass_i,
  input  logic              f1_pass_i,
  input  logic              b_pass_i,
  input  logic              zero_loss_i,
  input  logic              zero_final_i,
  input  logic              zero_weight_update_i,
  input  logic              err_valid_i,
  input  logic [LOSS_W-1:0] err_i,
  output logic [IDX_W-1:0]  step_o,
  output logic              fwd_step_o,
  output logic              bwd_step_o,
  output logic              f_end_o,
  output logic              b_end_o,
  output logic              zero_end_check_o,
  output logic [LOSS_W-1:0] loss_o,
  output logic [LOSS_W-1:0] final_loss_o,
  output logic [7:0]        upd_cnt_o
);

  typedef enum logic [2:0] {IDLE, FWD, FDONE, BWD, BDONE} state_t;

  localparam logic [IDX_W-1:0] FWD_LAST = IDX_W'(FWD_STEPS - 1);
  localparam logic [IDX_W-1:0] BWD_LAST = IDX_W'(BWD_STEPS - 1);

  state_t              state_q, state_d;
  logic                is_f1_q, is_f1_d;
  logic [IDX_W-1:0]    step_q, step_d;
  logic                f_end_q, f_end_d;
  logic                b_end_q, b_end_d;
  logic                zec_q, zec_d;
  logic [LOSS_W-1:0]   loss_q, loss_d;
  logic [LOSS_W-1:0]   final_q, final_d;
  logic [7:0]          upd_q, upd_d;

  logic [LOSS_W:0]     sum;
  logic [LOSS_W-1:0]   loss_sat;

  // One extra bit catches overflow so the accumulator can clamp at all-ones.
  assign sum      = {1'b0, loss_q} + {1'b0, err_i};
  assign loss_sat = sum[LOSS_W] ? '1 : sum[LOSS_W-1:0];

  always_comb begin
    state_d = state_q;
    is_f1_d = is_f1_q;
    step_d  = step_q;
    f_end_d = 1'b0;
    b_end_d = 1'b0;
    zec_d   = zec_q;
    loss_d  = loss_q;
    final_d = final_q;
    upd_d   = upd_q;

    case (state_q)
      IDLE: begin
        if (f0_pass_i || f1_pass_i) begin
          state_d = FWD;
          step_d  = '0;
          is_f1_d = !f0_pass_i;
        end else if (b_pass_i) begin
          state_d = BWD;
          step_d  = '0;
        end
      end
      FWD: begin
        if (err_valid_i) begin
          loss_d = loss_sat;
          if (step_q != FWD_LAST) begin
            step_d = step_q + IDX_W'(1);
          end else begin
            final_d = loss_sat;
            state_d = FDONE;
            // A converged f1 pass reports through the sticky flag, not f_end.
            if (is_f1_q && (loss_sat == '0)) zec_d = 1'b1;
            else f_end_d = 1'b1;
          end
        end
      end
      FDONE: begin
        if (!(is_f1_q ? f1_pass_i : f0_pass_i)) state_d = IDLE;
      end
      BWD: begin
        if (step_q == BWD_LAST) begin
          b_end_d = 1'b1;
          upd_d   = upd_q + 8'd1;
          state_d = BDONE;
        end else begin
          step_d = step_q + IDX_W'(1);
        end
      end
      BDONE: begin
        if (!b_pass_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear strobes override whatever the pass logic produced this cycle.
    if (zero_loss_i) loss_d = '0;
    if (zero_final_i) begin
      final_d = '0;
      zec_d   = 1'b0;
    end
    if (zero_weight_update_i) upd_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      is_f1_q <= 1'b0;
      step_q  <= '0;
      f_end_q <= 1'b0;
      b_end_q <= 1'b0;
      zec_q   <= 1'b0;
      loss_q  <= '0;
      final_q <= '0;
      upd_q   <= '0;
    end else if (en_i) begin
      state_q <= state_d;
      is_f1_q <= is_f1_d;
      step_q  <= step_d;
      f_end_q <= f_end_d;
      b_end_q <= b_end_d;
      zec_q   <= zec_d;
      loss_q  <= loss_d;
      final_q <= final_d;
      upd_q   <= upd_d;
    end
  end

  assign step_o           = step_q;
  assign fwd_step_o       = (state_q == FWD);
  assign bwd_step_o       = (state_q == BWD);
  assign f_end_o          = f_end_q;
  assign b_end_o          = b_end_q;
  assign zero_end_check_o = zec_q;
  assign loss_o           = loss_q;
  assign final_loss_o     = final_q;
  assign upd_cnt_o        = upd_q;

endmodule

// File: tb/tb_pass_engine.sv
// Bench for pass_engine: directed scenarios plus randomized passes checked
// against a pass-level model of loss, final loss, converged flag and count.
module tb_pass_engine;
  localparam int IDX_W = 3, FWD_STEPS = 8, BWD_STEPS = 4, LOSS_W = 8;

  logic              clk_i = 1'b0;
  logic              rst_i, en_i, f0_pass_i, f1_pass_i, b_pass_i;
  logic              zero_loss_i, zero_final_i, zero_weight_update_i;
  logic              err_valid_i;
  logic [LOSS_W-1:0] err_i;
  logic [IDX_W-1:0]  step_o;
  logic              fwd_step_o, bwd_step_o, f_end_o, b_end_o, zero_end_check_o;
  logic [LOSS_W-1:0] loss_o, final_loss_o;
  logic [7:0]        upd_cnt_o;

  pass_engine #(.IDX_W(IDX_W), .FWD_STEPS(FWD_STEPS), .BWD_STEPS(BWD_STEPS), .LOSS_W(LOSS_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .f0_pass_i(f0_pass_i), .f1_pass_i(f1_pass_i), .b_pass_i(b_pass_i),
    .zero_loss_i(zero_loss_i), .zero_final_i(zero_final_i),
    .zero_weight_update_i(zero_weight_update_i),
    .err_valid_i(err_valid_i), .err_i(err_i),
    .step_o(step_o), .fwd_step_o(fwd_step_o), .bwd_step_o(bwd_step_o),
    .f_end_o(f_end_o), .b_end_o(b_end_o), .zero_end_check_o(zero_end_check_o),
    .loss_o(loss_o), .final_loss_o(final_loss_o), .upd_cnt_o(upd_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [7:0] m_loss, m_final, m_upd;
  logic       m_zec;
  logic [7:0] err_tab[FWD_STEPS];

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = int'(a) + int'(b);
    return (s > 255) ? 8'hFF : 8'(s);
  endfunction

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic quiet_inputs();
    en_i = 1'b1; f0_pass_i = 1'b0; f1_pass_i = 1'b0; b_pass_i = 1'b0;
    zero_loss_i = 1'b0; zero_final_i = 1'b0; zero_weight_update_i = 1'b0;
    err_valid_i = 1'b0; err_i = '0;
  endtask

  task automatic clear_loss();
    zero_loss_i = 1'b1;
    cycle();
    zero_loss_i = 1'b0;
    m_loss = 8'h00;
    total++;
    if (loss_o !== m_loss) begin bad++; $display("FAIL clear_loss: got %0h expected %0h", loss_o, m_loss); end
  endtask

  task automatic clear_final();
    zero_final_i = 1'b1;
    cycle();
    zero_final_i = 1'b0;
    m_final = 8'h00;
    m_zec = 1'b0;
    total++;
    if ({zero_end_check_o, final_loss_o} !== {m_zec, m_final}) begin
      bad++; $display("FAIL clear_final: got zec=%0b final=%0h expected zec=%0b final=%0h",
                      zero_end_check_o, final_loss_o, m_zec, m_final);
    end
  endtask

  // Runs one forward pass over err_tab; clr_at >= 0 pulses zero_loss_i with that sample.
  task automatic do_fwd(input bit use_f0, input bit also_other, input int gap_min,
                        input int gap_max, input int clr_at, input bit stall);
    bit exp_f1, exp_fend;
    int gaps;
    exp_f1 = !use_f0;
    if (use_f0) begin f0_pass_i = 1'b1; f1_pass_i = also_other; end
    else begin f1_pass_i = 1'b1; b_pass_i = also_other; end
    cycle();
    total++;
    if ({fwd_step_o, bwd_step_o, step_o} !== {2'b10, 3'd0}) begin
      bad++; $display("FAIL fwd_start: got fwd=%0b bwd=%0b step=%0d expected fwd=1 bwd=0 step=0",
                      fwd_step_o, bwd_step_o, step_o);
    end
    for (int s = 0; s < FWD_STEPS; s++) begin
      gaps = $urandom_range(gap_max, gap_min);
      for (int g = 0; g < gaps; g++) begin
        err_valid_i = 1'b0;
        err_i = 8'($urandom);
        cycle();
        total++;
        if (step_o !== 3'(s)) begin bad++; $display("FAIL fwd_hold: got step=%0d expected %0d", step_o, s); end
      end
      err_valid_i = 1'b1;
      err_i = err_tab[s];
      zero_loss_i = (s == clr_at);
      m_loss = (s == clr_at) ? 8'h00 : sat_add(m_loss, err_tab[s]);
      cycle();
      err_valid_i = 1'b0;
      zero_loss_i = 1'b0;
      if (s < FWD_STEPS - 1) begin
        total++;
        if ({step_o, loss_o, f_end_o} !== {3'(s + 1), m_loss, 1'b0}) begin
          bad++; $display("FAIL fwd_step: got step=%0d loss=%0h f_end=%0b expected step=%0d loss=%0h f_end=0",
                          step_o, loss_o, f_end_o, s + 1, m_loss);
        end
      end
    end
    m_final = m_loss;
    exp_fend = !(exp_f1 && (m_loss == 8'h00));
    if (!exp_fend) m_zec = 1'b1;
    total++;
    if ({f_end_o, final_loss_o, loss_o, zero_end_check_o, fwd_step_o} !==
        {exp_fend, m_final, m_loss, m_zec, 1'b0}) begin
      bad++; $display("FAIL fwd_end: got f_end=%0b final=%0h loss=%0h zec=%0b fwd=%0b expected f_end=%0b final=%0h loss=%0h zec=%0b fwd=0",
                      f_end_o, final_loss_o, loss_o, zero_end_check_o, fwd_step_o, exp_fend, m_final, m_loss, m_zec);
    end
    if (stall) begin
      en_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
        err_valid_i = 1'b1;
        err_i = 8'($urandom_range(255, 1));
        cycle();
        total++;
        if ({f_end_o, step_o, loss_o} !== {exp_fend, 3'(FWD_STEPS - 1), m_loss}) begin
          bad++; $display("FAIL stall_hold: got f_end=%0b step=%0d loss=%0h expected f_end=%0b step=%0d loss=%0h",
                          f_end_o, step_o, loss_o, exp_fend, FWD_STEPS - 1, m_loss);
        end
      end
      en_i = 1'b1;
    end
    // Start level stays high: no second pulse, no retrigger, stray errors ignored.
    for (int k = 0; k < 3; k++) begin
      err_valid_i = 1'b1;
      err_i = 8'($urandom_range(255, 1));
      cycle();
      total++;
      if ({f_end_o, fwd_step_o, loss_o} !== {2'b00, m_loss}) begin
        bad++; $display("FAIL fwd_no_retrigger: got f_end=%0b fwd=%0b loss=%0h expected f_end=0 fwd=0 loss=%0h",
                        f_end_o, fwd_step_o, loss_o, m_loss);
      end
    end
    f0_pass_i = 1'b0; f1_pass_i = 1'b0; b_pass_i = 1'b0; err_valid_i = 1'b0;
    cycle();
  endtask

  task automatic do_bwd(input bit clr_at_end);
    b_pass_i = 1'b1;
    cycle();
    for (int i = 0; i < BWD_STEPS; i++) begin
      total++;
      if ({bwd_step_o, fwd_step_o, step_o, b_end_o} !== {2'b10, 3'(i), 1'b0}) begin
        bad++; $display("FAIL bwd_step: got bwd=%0b fwd=%0b step=%0d b_end=%0b expected bwd=1 fwd=0 step=%0d b_end=0",
                        bwd_step_o, fwd_step_o, step_o, b_end_o, i);
      end
      if (i == BWD_STEPS - 1) zero_weight_update_i = clr_at_end;
      cycle();
    end
    zero_weight_update_i = 1'b0;
    m_upd = clr_at_end ? 8'h00 : m_upd + 8'd1;
    total++;
    if ({b_end_o, upd_cnt_o, bwd_step_o} !== {1'b1, m_upd, 1'b0}) begin
      bad++; $display("FAIL bwd_end: got b_end=%0b upd=%0d bwd=%0b expected b_end=1 upd=%0d bwd=0",
                      b_end_o, upd_cnt_o, bwd_step_o, m_upd);
    end
    cycle();
    total++;
    if ({b_end_o, bwd_step_o, upd_cnt_o} !== {2'b00, m_upd}) begin
      bad++; $display("FAIL bwd_single: got b_end=%0b bwd=%0b upd=%0d expected b_end=0 bwd=0 upd=%0d",
                      b_end_o, bwd_step_o, upd_cnt_o, m_upd);
    end
    b_pass_i = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst_i = 1'b0;
    m_loss = 0; m_final = 0; m_upd = 0; m_zec = 0;
    repeat (3) cycle();
    total++;
    if ({step_o, fwd_step_o, bwd_step_o, f_end_o, b_end_o, zero_end_check_o, loss_o, final_loss_o, upd_cnt_o} !== 32'd0) begin
      bad++; $display("FAIL reset_values: got step=%0d loss=%0h final=%0h upd=%0d expected all zero", step_o, loss_o, final_loss_o, upd_cnt_o);
    end
    @(negedge clk_i); rst_i = 1'b1;
    cycle();
    f0_pass_i = 1'b1;
    cycle();
    err_tab[0] = 8'h10; err_tab[1] = 8'h08; err_tab[2] = 8'h08;
    for (int s = 0; s < 3; s++) begin
      err_valid_i = 1'b1; err_i = err_tab[s];
      cycle();
    end
    err_valid_i = 1'b0;
    total++;
    if ({fwd_step_o, step_o, loss_o} !== {1'b1, 3'd3, 8'h20}) begin
      bad++; $display("FAIL reset_setup: got fwd=%0b step=%0d loss=%0h expected fwd=1 step=3 loss=20", fwd_step_o, step_o, loss_o);
    end
    #2 rst_i = 1'b0;
    #1;
    total++;
    if ({step_o, fwd_step_o, bwd_step_o, f_end_o, b_end_o, zero_end_check_o, loss_o, final_loss_o, upd_cnt_o} !== 32'd0) begin
      bad++; $display("FAIL reset_async: got step=%0d fwd=%0b loss=%0h expected all zero", step_o, fwd_step_o, loss_o);
    end
    @(negedge clk_i); rst_i = 1'b1;
    cycle();
    total++;
    if ({fwd_step_o, step_o, loss_o} !== {1'b1, 3'd0, 8'h00}) begin
      bad++; $display("FAIL reset_restart: got fwd=%0b step=%0d loss=%0h expected fwd=1 step=0 loss=0", fwd_step_o, step_o, loss_o);
    end
    // Leave the block idle with reset values again.
    rst_i = 1'b0;
    f0_pass_i = 1'b0;
    #2;
    @(negedge clk_i); rst_i = 1'b1;
    cycle();
  endtask

  task automatic test_fwd_f0();
    for (int s = 0; s < FWD_STEPS; s++) err_tab[s] = 8'd5;
    do_fwd(1'b1, 1'b0, 1, 1, -1, 1'b0);
    total++;
    if (final_loss_o !== 8'd40) begin bad++; $display("FAIL f0_total: got %0d expected 40", final_loss_o); end
  endtask

  task automatic test_bwd();
    do_bwd(1'b0);
    do_bwd(1'b1);
  endtask

  task automatic test_f1_zero();
    clear_loss();
    for (int s = 0; s < FWD_STEPS; s++) err_tab[s] = 8'd0;
    do_fwd(1'b0, 1'b0, 0, 2, -1, 1'b0);
    repeat (3) cycle();
    total++;
    if (zero_end_check_o !== 1'b1) begin bad++; $display("FAIL zec_held: got %0b expected 1", zero_end_check_o); end
    clear_final();
    clear_loss();
    err_tab[$urandom_range(FWD_STEPS - 1, 0)] = 8'd1;
    do_fwd(1'b0, 1'b0, 0, 1, -1, 1'b0);
    total++;
    if ({final_loss_o, zero_end_check_o} !== {8'd1, 1'b0}) begin
      bad++; $display("FAIL f1_nonzero: got final=%0d zec=%0b expected final=1 zec=0", final_loss_o, zero_end_check_o);
    end
  endtask

  task automatic test_saturation();
    clear_loss();
    for (int s = 0; s < FWD_STEPS; s++) err_tab[s] = 8'hF0;
    do_fwd(1'b1, 1'b0, 0, 1, -1, 1'b0);
    total++;
    if (loss_o !== 8'hFF) begin bad++; $display("FAIL saturate: got %0h expected ff", loss_o); end
    clear_loss();
    for (int s = 0; s < FWD_STEPS; s++) err_tab[s] = 8'($urandom_range(40, 1));
    do_fwd(1'b1, 1'b0, 0, 1, $urandom_range(FWD_STEPS - 2, 0), 1'b0);
  endtask

  task automatic test_stall();
    clear_loss();
    for (int s = 0; s < FWD_STEPS; s++) err_tab[s] = 8'($urandom_range(30, 0));
    do_fwd(1'b1, 1'b0, 0, 1, -1, 1'b1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(3, 0) == 0) clear_loss();
      if ($urandom_range(5, 0) == 0) clear_final();
      if ($urandom_range(2, 0) == 0) begin
        do_bwd($urandom_range(3, 0) == 0);
      end else begin
        if ($urandom_range(3, 0) == 0) begin
          for (int s = 0; s < FWD_STEPS; s++) err_tab[s] = 8'd0;
        end else begin
          for (int s = 0; s < FWD_STEPS; s++) err_tab[s] = 8'($urandom_range(60, 0));
        end
        do_fwd($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, 0, 2,
               ($urandom_range(4, 0) == 0) ? int'($urandom_range(FWD_STEPS - 2, 0)) : -1,
               $urandom_range(4, 0) == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fwd_f0();
    test_bwd();
    test_f1_zero();
    test_saturation();
    test_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
